// File: rtl/signed_product_writeback.sv
// Registered writeback stage for the 64-bit signed multiplier product: reduces to 32 bits and queues
// results with flags in a small FIFO. Optional sticky overflow flag enabled by macro STICKY_OVF_EN.
module signed_product_writeback #(
  parameter int DEPTH  = 2,
  parameter int PROD_W = 64,
  parameter int OUT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_result,
  output logic              out_ovf,
  output logic              out_zero,
  output logic              out_neg
`ifdef STICKY_OVF_EN
  ,
  input  logic              ovf_clr,
  output logic              ovf_sticky
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic             neg;
    logic             zero;
    logic             ovf;
    logic [OUT_W-1:0] result;
  } entry_t;

  // Narrow the product; overflow means bits [PROD_W-1:OUT_W-1] are not a pure sign extension.
  function automatic entry_t reduce(input logic [PROD_W-1:0] p, input logic [1:0] mode);
    logic [PROD_W-OUT_W:0] top;
    logic                  ovf64;
    entry_t                e;
    top   = p[PROD_W-1:OUT_W-1];
    ovf64 = (top != {(PROD_W-OUT_W+1){1'b0}}) && (top != {(PROD_W-OUT_W+1){1'b1}});
    case (mode)
      2'b01: begin
        e.result = p[PROD_W-1:OUT_W];
        e.ovf    = 1'b0;
      end
      2'b10: begin
        e.ovf = ovf64;
        if (!ovf64) begin
          e.result = p[OUT_W-1:0];
        end else if (p[PROD_W-1]) begin
          e.result = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
          e.result = {1'b0, {(OUT_W-1){1'b1}}};
        end
      end
      default: begin
        e.result = p[OUT_W-1:0];
        e.ovf    = ovf64;
      end
    endcase
    e.zero = (e.result == {OUT_W{1'b0}});
    e.neg  = e.result[OUT_W-1];
    return e;
  endfunction

  entry_t          mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            push_s;
  logic            pop_s;
  entry_t          head_s;

  assign in_ready  = (count_r != CW'(DEPTH));
  assign out_valid = (count_r != {CW{1'b0}});
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  assign head_s     = mem_r[rd_ptr_r];
  assign out_result = head_s.result;
  assign out_ovf    = head_s.ovf;
  assign out_zero   = head_s.zero;
  assign out_neg    = head_s.neg;

  // FIFO storage: entries cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= reduce(in_product, in_mode);
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef STICKY_OVF_EN
  logic ovf_sticky_r;
  assign ovf_sticky = ovf_sticky_r;

  // Sticky overflow: an overflowing pop takes priority over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky_r <= 1'b0;
    end else if (pop_s && out_ovf) begin
      ovf_sticky_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky_r <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_signed_product_writeback.sv
// Self-checking bench for signed_product_writeback: directed vectors plus random traffic against a
// queue-based reference model. Define STICKY_OVF_EN to exercise the sticky overflow flag.
module tb_signed_product_writeback;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_product;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_zero;
  logic        out_neg;
`ifdef STICKY_OVF_EN
  logic        ovf_clr;
  logic        ovf_sticky;
`endif

  signed_product_writeback #(.DEPTH(DEPTH), .PROD_W(64), .OUT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero),
    .out_neg    (out_neg)
`ifdef STICKY_OVF_EN
    ,
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        ovf;
    logic        zero;
    logic        neg;
  } exp_t;

  exp_t q[$];
  logic m_sticky;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference reduction from the arithmetic value of the product.
  function automatic exp_t ref_reduce(input logic [63:0] prod, input logic [1:0] mode);
    exp_t    e;
    longint  v;
    bit      big;
    v   = longint'(prod);
    big = (v > 64'sd2147483647) || (v < -64'sd2147483648);
    if (mode == 2'd1) begin
      e.r   = prod[63:32];
      e.ovf = 1'b0;
    end else if (mode == 2'd2) begin
      e.ovf = big;
      e.r   = !big ? prod[31:0] : (v < 0 ? 32'h8000_0000 : 32'h7FFF_FFFF);
    end else begin
      e.r   = prod[31:0];
      e.ovf = big;
    end
    e.zero = (e.r == 32'd0);
    e.neg  = e.r[31];
    return e;
  endfunction

  task automatic check_model();
    chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_result", 64'(out_result), 64'(q[0].r));
      chk("out_flags", {61'd0, out_ovf, out_zero, out_neg}, {61'd0, q[0].ovf, q[0].zero, q[0].neg});
    end
`ifdef STICKY_OVF_EN
    chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
`endif
  endtask

  // One clock: drive inputs after a falling edge, advance the model at the rising edge, check.
  task automatic step(input logic iv, input logic [63:0] prod, input logic [1:0] mode,
                      input logic ordy, input logic clr);
    bit m_push, m_pop, m_set;
    in_valid   = iv;
    in_product = prod;
    in_mode    = mode;
    out_ready  = ordy;
`ifdef STICKY_OVF_EN
    ovf_clr    = clr;
`endif
    m_push = iv && (q.size() < DEPTH);
    m_pop  = ordy && (q.size() > 0);
    m_set  = m_pop && q[0].ovf;
    @(posedge clk);
    if (m_pop) void'(q.pop_front());
    if (m_push) q.push_back(ref_reduce(prod, mode));
    if (m_set) m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
    @(negedge clk);
    check_model();
  endtask

  task automatic chk_head(input string tag, input logic [31:0] r, input logic [2:0] flags);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_result"}, 64'(out_result), 64'(r));
    chk({tag, "_ovf_zero_neg"}, 64'({out_ovf, out_zero, out_neg}), 64'(flags));
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] w;
    longint      b;
    rst = 1'b1; in_valid = 1'b0; in_product = 64'd0; in_mode = 2'd0; out_ready = 1'b0;
`ifdef STICKY_OVF_EN
    ovf_clr = 1'b0;
`endif
    m_sticky = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_flags", 64'({out_ovf, out_zero, out_neg}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // LO then HI of the same product
    step(1'b1, 64'h0000_0001_2345_6789, 2'd0, 1'b1, 1'b0);
    chk_head("lo", 32'h2345_6789, 3'b100);
    step(1'b1, 64'h0000_0001_2345_6789, 2'd1, 1'b1, 1'b0);
    chk_head("hi", 32'h0000_0001, 3'b000);
    step(1'b0, 64'd0, 2'd0, 1'b1, 1'b0);

    // Saturation, negative overflow and in-range negative
    step(1'b1, 64'hFFFF_FF00_0000_0000, 2'd2, 1'b1, 1'b0);
    chk_head("sat_neg", 32'h8000_0000, 3'b101);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 2'd2, 1'b1, 1'b0);
    chk_head("sat_inrange", 32'hFFFF_FFFE, 3'b001);
    step(1'b1, 64'h0000_0000_8000_0000, 2'd2, 1'b1, 1'b0);
    chk_head("sat_pos", 32'h7FFF_FFFF, 3'b100);
    step(1'b1, 64'h0000_0000_8000_0000, 2'd3, 1'b1, 1'b0);
    chk_head("mode3_lo", 32'h8000_0000, 3'b101);
    step(1'b0, 64'd0, 2'd0, 1'b1, 1'b0);
    chk("drained", 64'(out_valid), 64'd0);

    // Zero result appears one cycle after the push
    step(1'b1, 64'd0, 2'd0, 1'b0, 1'b0);
    chk_head("zero", 32'd0, 3'b010);
    step(1'b0, 64'd0, 2'd0, 1'b1, 1'b0);

    // Backpressure: third push held until a slot is free, strict order afterwards
    step(1'b1, 64'h11, 2'd0, 1'b0, 1'b0);
    step(1'b1, 64'h22, 2'd0, 1'b0, 1'b0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 64'h33, 2'd0, 1'b0, 1'b0);
    chk_head("full_hold", 32'h11, 3'b000);
    step(1'b1, 64'h33, 2'd0, 1'b1, 1'b0);
    chk_head("order_b", 32'h22, 3'b000);
    chk("reopen_in_ready", 64'(in_ready), 64'd1);
    step(1'b1, 64'h33, 2'd0, 1'b1, 1'b0);
    chk_head("order_c", 32'h33, 3'b000);
    step(1'b0, 64'd0, 2'd0, 1'b1, 1'b0);
    chk("no_dup", 64'(out_valid), 64'd0);

`ifdef STICKY_OVF_EN
    step(1'b1, 64'h1_0000_0000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 64'd0, 2'd0, 1'b1, 1'b0);
    chk("sticky_set", 64'(ovf_sticky), 64'd1);
    step(1'b0, 64'd0, 2'd0, 1'b0, 1'b1);
    chk("sticky_clr", 64'(ovf_sticky), 64'd0);
    step(1'b1, 64'h1_0000_0000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 64'd0, 2'd0, 1'b1, 1'b1);
    chk("sticky_set_wins", 64'(ovf_sticky), 64'd1);
    step(1'b0, 64'd0, 2'd0, 1'b0, 1'b1);
`endif

    // Random traffic across all modes and near the overflow boundaries
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: p = {$urandom, $urandom};
        1: p = {{32{w[31]}}, w};
        2: begin
          b = 64'sd2147483647 + longint'($urandom_range(0, 2)) - 64'sd1;
          p = w[0] ? 64'(b) : 64'(-b - 64'sd1);
        end
        default: p = w[1] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
      endcase
      step(1'($urandom_range(0, 1)), p, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset with two entries buffered
    step(1'b0, 64'd0, 2'd0, 1'b1, 1'b0);
    step(1'b0, 64'd0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 64'h0000_0000_1234_5678, 2'd0, 1'b0, 1'b0);
    step(1'b1, 64'h0000_0000_0BAD_F00D, 2'd0, 1'b0, 1'b0);
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    chk("async_rst_out_result", 64'(out_result), 64'd0);
    q.delete();
    m_sticky = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 64'h0000_0000_0000_0042, 2'd0, 1'b1, 1'b0);
    chk_head("post_rst", 32'h42, 3'b000);
    step(1'b0, 64'd0, 2'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
